// File: rtl/dac_glitch_scheduler_pkg.sv
// Shared definitions for the DAC glitch scheduler and its trigger matchers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dac_glitch_scheduler_pkg;

    // Scheduler FSM encodings; the numeric values are exported on the debug state port.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_DELAY   = 3'd2,
        ST_GLITCH  = 3'd3,
        ST_HOLDOFF = 3'd4
    } state_t;

    // Sniffer decode layout: [8:1] data byte, [0] ACK bit (0 = ACKed).
    localparam int BYTE_W   = 9;
    localparam int DATA_MSB = 8;
    localparam int DATA_LSB = 1;
    localparam int ACK_BIT  = 0;

endpackage

// File: rtl/dac_glitch_scheduler_if.sv
// Sniffer streams, core level and trigger configuration feeding the glitch scheduler.
// Latency: n/a (wiring only).
// Backpressure: none; ready strobes are one-cycle and cannot be stalled.
interface dac_glitch_scheduler_if
    import dac_glitch_scheduler_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic [BYTE_W-1:0] priv_byte;
    logic              priv_ready;
    logic [BYTE_W-1:0] main_byte;
    logic              main_ready;
    logic [7:0]        core_level;
    logic              arm;
    logic              abort;
    logic              trig_src;
    logic [7:0]        trig_byte;
    logic [CNT_W-1:0]  delay;
    logic [CNT_W-1:0]  width;
    logic [7:0]        glitch_level;

    modport master (
        output priv_byte, priv_ready, main_byte, main_ready, core_level,
        output arm, abort, trig_src, trig_byte, delay, width, glitch_level
    );

    modport slave (
        input priv_byte, priv_ready, main_byte, main_ready, core_level,
        input arm, abort, trig_src, trig_byte, delay, width, glitch_level
    );
endinterface

// File: rtl/dac_glitch_scheduler_i2c_byte_match.sv
// Selects one sniffer stream and flags a byte equal to the trigger value.
// Latency: combinational, match valid in the same cycle as the ready strobe.
// Backpressure: none; an unselected or mismatching strobe is simply dropped.
module i2c_byte_match
    import dac_glitch_scheduler_pkg::*;
#(
    parameter bit REQUIRE_ACK = 1'b1
) (
    input  logic [BYTE_W-1:0] priv_byte,
    input  logic              priv_ready,
    input  logic [BYTE_W-1:0] main_byte,
    input  logic              main_ready,
    input  logic              sel,
    input  logic [7:0]        trig_byte,
    output logic              match
);
    logic [BYTE_W-1:0] sel_byte;
    logic              sel_ready;
    logic              ack_ok;

    // Only the selected stream can trigger, so simultaneous strobes need no arbitration.
    always_comb begin
        sel_byte  = sel ? main_byte  : priv_byte;
        sel_ready = sel ? main_ready : priv_ready;
        ack_ok    = !REQUIRE_ACK || !sel_byte[ACK_BIT];
        match     = sel_ready && (sel_byte[DATA_MSB:DATA_LSB] == trig_byte) && ack_ok;
    end
endmodule

// File: rtl/dac_glitch_scheduler.sv
// Passes the core DAC level through, substituting a glitch level for a timed window after a trigger byte.
// Latency: dac_level is registered, 1 cycle from core_level; glitch starts delay+1 cycles after the match edge.
// Backpressure: none; matches outside ARMED are dropped, abort returns to IDLE on the next cycle.
module dac_glitch_scheduler
    import dac_glitch_scheduler_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int HOLDOFF     = 4,
    parameter bit REQUIRE_ACK = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    dac_glitch_scheduler_if.slave  ctl,
    output logic [7:0]             dac_level,
    output logic [2:0]             state,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             fire_count
);
    localparam logic [CNT_W-1:0] HOLDOFF_CNT = CNT_W'(HOLDOFF);
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic             cfg_src;
    logic [7:0]       cfg_byte;
    logic [CNT_W-1:0] cfg_delay;
    logic [CNT_W-1:0] cfg_width;
    logic [7:0]       cfg_level;

    logic             latch_cfg;
    logic             fire;
    logic             holdoff_exit;
    logic             match;

    // Trigger compare runs against the latched config so mid-run input changes are ignored.
    i2c_byte_match #(
        .REQUIRE_ACK (REQUIRE_ACK)
    ) u_match (
        .priv_byte  (ctl.priv_byte),
        .priv_ready (ctl.priv_ready),
        .main_byte  (ctl.main_byte),
        .main_ready (ctl.main_ready),
        .sel        (cfg_src),
        .trig_byte  (cfg_byte),
        .match      (match)
    );

    // State and shared down-counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter load/decrement; abort overrides everything including arm.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        latch_cfg    = 1'b0;
        fire         = 1'b0;
        holdoff_exit = 1'b0;
        if (ctl.abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ctl.arm) begin
                        state_d   = ST_ARMED;
                        latch_cfg = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (!ctl.arm) begin
                        state_d = ST_IDLE;
                    end else if (match) begin
                        state_d = ST_DELAY;
                        cnt_d   = cfg_delay;
                    end
                end
                ST_DELAY: begin
                    if (cnt_q == '0) begin
                        if (cfg_width != '0) begin
                            // Load width-1 so the glitch lasts exactly width cycles.
                            state_d = ST_GLITCH;
                            cnt_d   = cfg_width - ONE;
                        end else begin
                            state_d = ST_HOLDOFF;
                            cnt_d   = HOLDOFF_CNT;
                        end
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                ST_GLITCH: begin
                    if (cnt_q == '0) begin
                        state_d = ST_HOLDOFF;
                        cnt_d   = HOLDOFF_CNT;
                        fire    = 1'b1;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt_q == '0) begin
                        state_d      = ST_IDLE;
                        holdoff_exit = 1'b1;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Debug/status outputs decoded from the current state.
    always_comb begin
        state = state_q;
        busy  = (state_q != ST_IDLE);
    end

    // Capture the trigger configuration on the IDLE->ARMED transition only.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_src   <= 1'b0;
            cfg_byte  <= '0;
            cfg_delay <= '0;
            cfg_width <= '0;
            cfg_level <= '0;
        end else if (latch_cfg) begin
            cfg_src   <= ctl.trig_src;
            cfg_byte  <= ctl.trig_byte;
            cfg_delay <= ctl.delay;
            cfg_width <= ctl.width;
            cfg_level <= ctl.glitch_level;
        end
    end

    // DAC drive keys off the next state so the glitch lands on the same edge GLITCH is entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            dac_level  <= '0;
            done       <= 1'b0;
            fire_count <= '0;
        end else begin
            dac_level <= (state_d == ST_GLITCH) ? cfg_level : ctl.core_level;
            done      <= holdoff_exit;
            if (fire) begin
                fire_count <= fire_count + 8'd1;
            end
        end
    end
endmodule
